booth_mult_seq: RTL and testbench
=================================

Name: booth_mult_seq

Overview:
- Parametrised, iterative radix-2 Booth multiplier for signed two's-complement operands.
- Reuses the add/subtract-then-shift datapath idea of the team's 8-bit adder/subtractor. Width is generic, and the block adds a controller, an iteration counter and a start/busy/done handshake.
- Serves as the multiply engine of the Booth multiplier top level. It trades area for latency: one partial-product step per clock.

Parameters:
- WIDTH, 8, operand width in bits (>= 2); product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not to be overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while idle.
- multiplicand  input  WIDTH  signed operand M; captured on the accepted start.
- multiplier  input  WIDTH  signed operand Q; captured on the accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle completion pulse.
- product  output  2*WIDTH  signed result M*Q; held until the next completion.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low; all state is cleared immediately on rst_n=0.
- Reset values: busy=0, done=0, product=0, state=IDLE, counter=0, internal A/Q/Q-1/M registers=0.
- States: IDLE, RUN.
- IDLE: at a clock edge with start=1, the block:
  - captures M sign-extended to WIDTH+1 bits;
  - sets A=0 (WIDTH+1 bits), Q=multiplier, Q-1=0, count=0;
  - sets busy=1 and goes to RUN.
- RUN, each edge:
  - Examine {Q[0],Q-1}: 01 -> A=A+M; 10 -> A=A-M; 00/11 -> A unchanged. Arithmetic is WIDTH+1 bits.
  - Then arithmetic-shift-right the concatenation {A,Q,Q-1} by one, replicating A's MSB.
  - count increments.
- Completion: on the edge where count==WIDTH-1 (the WIDTH-th iteration), the block:
  - loads product={A[WIDTH-1:0],Q} from the post-shift value;
  - sets done=1, busy=0 and returns to IDLE.
- Timing:
  - Latency: start sampled at edge t -> done high during the cycle after edge t+WIDTH, i.e. WIDTH cycles.
  - Throughput: one result per WIDTH+1 cycles when start is held high.
- done: registered, high for exactly one cycle, cleared at the next edge.
- A is WIDTH+1 bits so that M = -2^(WIDTH-1) never overflows during subtraction. Result is exact for every operand pair, including (-2^(WIDTH-1))^2.
- start while busy=1: ignored, with no effect on operands or state. Operand inputs may change freely during RUN.
- start=1 in the cycle done=1: accepted (state is IDLE). The new operation begins and product keeps the previous result until the new completion.
- rst_n asserted mid-RUN: the operation is aborted, outputs return to reset values, and no done pulse is generated.
- Handshake timing: busy rises the cycle after start is accepted. product changes only on the completion edge or on reset.
- No combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, M=7, Q=3, start pulse:
  - busy high for 8 cycles, then done pulses once with product=0x0015;
  - product stable afterwards.
- WIDTH=8, sign/extreme cases:
  - (-128)*(-128) -> 0x4000;
  - (-128)*127 -> 0xC080;
  - 5*(-1) -> 0xFFFB;
  - 0*(-77) -> 0x0000.
- WIDTH=8, start held high continuously with operands changed every cycle:
  - each result uses only operands captured at its accept edge;
  - done period is 9 cycles;
  - start during busy causes no corruption.
- WIDTH=8, rst_n low at the 4th RUN cycle of 100*(-3):
  - busy, done and product go 0 immediately;
  - no done pulse appears;
  - the next operation 100*(-3) gives 0xFED4.
- WIDTH=16 and WIDTH=3, 1000 random signed pairs each:
  - product equals the signed reference product;
  - latency is exactly WIDTH cycles.

Source files
------------

// File: rtl/booth_mult_seq.sv
// Iterative radix-2 Booth multiplier for signed operands, one add/sub-and-shift step per clock.
// Latency: WIDTH cycles from accepted start to the done pulse; one result per WIDTH+1 cycles.
// Backpressure: start is sampled only while idle and is ignored while busy.
module booth_mult_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH:0]   a_reg, m_reg;
  logic [WIDTH-1:0] q_reg;
  logic             qm1_reg;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   a_shf;
  logic [WIDTH-1:0] q_shf;
  logic             last;

  // A carries one guard bit so subtracting the most negative M cannot overflow.
  always_comb begin
    sum = a_reg;
    case ({q_reg[0], qm1_reg})
      2'b01:   sum = a_reg + m_reg;
      2'b10:   sum = a_reg - m_reg;
      default: sum = a_reg;
    endcase
    a_shf = {sum[WIDTH], sum[WIDTH:1]};
    q_shf = {sum[0], q_reg[WIDTH-1:1]};
  end

  assign last = (cnt == CNT_W'(WIDTH - 1));
  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      m_reg   <= '0;
      q_reg   <= '0;
      qm1_reg <= 1'b0;
      cnt     <= '0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          m_reg   <= {multiplicand[WIDTH-1], multiplicand};
          a_reg   <= '0;
          q_reg   <= multiplier;
          qm1_reg <= 1'b0;
          cnt     <= '0;
        end
      end else begin
        a_reg   <= a_shf;
        q_reg   <= q_shf;
        qm1_reg <= q_reg[0];
        cnt     <= cnt + 1'b1;
        if (last) begin
          product <= {a_shf[WIDTH-1:0], q_shf};
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboarded bench for booth_mult_seq at WIDTH 8, 16 and 3 against plain signed multiplication.
// The accept/complete schedule is modelled from the handshake rules, not from the RTL.
module tb_booth_mult_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s8 = 1'b0, s16 = 1'b0, s3 = 1'b0;
  logic [7:0]  m8 = '0, q8 = '0;
  logic [15:0] m16 = '0, q16 = '0;
  logic [2:0]  m3 = '0, q3 = '0;
  logic        busy8, busy16, busy3, done8, done16, done3;
  logic [15:0] p8;
  logic [31:0] p16;
  logic [5:0]  p3;

  booth_mult_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .multiplicand(m8), .multiplier(q8),
    .busy(busy8), .done(done8), .product(p8));
  booth_mult_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(s16), .multiplicand(m16), .multiplier(q16),
    .busy(busy16), .done(done16), .product(p16));
  booth_mult_seq #(.WIDTH(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(s3), .multiplicand(m3), .multiplier(q3),
    .busy(busy3), .done(done3), .product(p3));

  typedef struct { logic [31:0] prod; int acc; } exp_t;
  exp_t sb8[$], sb16[$], sb3[$];
  int cyc = 0;
  int free8 = 0, free16 = 0, free3 = 0;
  logic [31:0] last8 = '0, last16 = '0, last3 = '0;
  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference: an idle engine accepts start; the next accept is allowed WIDTH+1 edges later.
  always @(posedge clk) begin
    int r;
    if (rst_n && s8 && cyc >= free8) begin
      r = int'($signed(m8)) * int'($signed(q8));
      sb8.push_back('{32'(r) & 32'h0000_FFFF, cyc});
      free8 = cyc + 9;
    end
    if (rst_n && s16 && cyc >= free16) begin
      r = int'($signed(m16)) * int'($signed(q16));
      sb16.push_back('{32'(r), cyc});
      free16 = cyc + 17;
    end
    if (rst_n && s3 && cyc >= free3) begin
      r = int'($signed(m3)) * int'($signed(q3));
      sb3.push_back('{32'(r) & 32'h0000_003F, cyc});
      free3 = cyc + 4;
    end
    cyc <= cyc + 1;
  end

  always @(negedge rst_n) begin
    sb8.delete(); sb16.delete(); sb3.delete();
    free8 = 0; free16 = 0; free3 = 0;
    last8 = '0; last16 = '0; last3 = '0;
  end

  // Monitors: done is due exactly WIDTH cycles after the accept edge.
  always @(negedge clk) begin
    logic ed;
    ed = (sb8.size() > 0) && (cyc == sb8[0].acc + 9);
    check("done8", 32'(done8), 32'(ed));
    check("busy8", 32'(busy8), 32'((sb8.size() > 0) && !ed));
    if (ed) begin last8 = sb8[0].prod; void'(sb8.pop_front()); end
    check("prod8", 32'(p8), last8);
  end

  always @(negedge clk) begin
    logic ed;
    ed = (sb16.size() > 0) && (cyc == sb16[0].acc + 17);
    check("done16", 32'(done16), 32'(ed));
    check("busy16", 32'(busy16), 32'((sb16.size() > 0) && !ed));
    if (ed) begin last16 = sb16[0].prod; void'(sb16.pop_front()); end
    check("prod16", p16, last16);
  end

  always @(negedge clk) begin
    logic ed;
    ed = (sb3.size() > 0) && (cyc == sb3[0].acc + 4);
    check("done3", 32'(done3), 32'(ed));
    check("busy3", 32'(busy3), 32'((sb3.size() > 0) && !ed));
    if (ed) begin last3 = sb3[0].prod; void'(sb3.pop_front()); end
    check("prod3", 32'(p3), last3);
  end

  task automatic wait_idle8();
    for (int i = 0; i < 40 && sb8.size() > 0; i++) begin
      @(negedge clk); #1;
      m8 = 8'($urandom); q8 = 8'($urandom);
    end
    check("timeout8", 32'(sb8.size()), 32'd0);
  endtask

  task automatic wait_idle16();
    for (int i = 0; i < 40 && sb16.size() > 0; i++) begin
      @(negedge clk); #1;
      m16 = 16'($urandom); q16 = 16'($urandom);
    end
    check("timeout16", 32'(sb16.size()), 32'd0);
  endtask

  task automatic wait_idle3();
    for (int i = 0; i < 20 && sb3.size() > 0; i++) begin
      @(negedge clk); #1;
      m3 = 3'($urandom); q3 = 3'($urandom);
    end
    check("timeout3", 32'(sb3.size()), 32'd0);
  endtask

  task automatic op8(input logic [7:0] m, input logic [7:0] q, input logic [15:0] exp, input string name);
    @(negedge clk); #1;
    s8 = 1'b1; m8 = m; q8 = q;
    @(negedge clk); #1;
    s8 = 1'b0;
    wait_idle8();
    check(name, 32'(p8), 32'(exp));
    repeat (3) @(negedge clk);
    check({name, "_hold"}, 32'(p8), 32'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_prod", 32'(p8), 32'd0);
    #1 rst_n = 1'b1;

    op8(8'd7,    8'd3,    16'h0015, "m7xq3");
    op8(8'h80,   8'h80,   16'h4000, "neg128sq");
    op8(8'h80,   8'd127,  16'hC080, "neg128x127");
    op8(8'd5,    8'hFF,   16'hFFFB, "m5xneg1");
    op8(8'd0,    8'hB3,   16'h0000, "zeroxneg77");

    // Start held high with operands changing every cycle.
    @(negedge clk); #1;
    s8 = 1'b1;
    repeat (54) begin
      @(negedge clk); #1;
      m8 = 8'($urandom); q8 = 8'($urandom);
    end
    s8 = 1'b0;
    wait_idle8();

    // Abort 100*(-3) during its 4th RUN cycle.
    @(negedge clk); #1;
    s8 = 1'b1; m8 = 8'd100; q8 = 8'hFD;
    @(negedge clk); #1;
    s8 = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("busy_before_rst", 32'(busy8), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_prod", 32'(p8), 32'd0);
    repeat (12) @(negedge clk);
    #1 rst_n = 1'b1;
    op8(8'd100, 8'hFD, 16'hFED4, "after_abort");

    fork
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk); #1;
        s16 = 1'b1;
        if (i == 0) begin m16 = 16'h8000; q16 = 16'h8000; end
        else if (i == 1) begin m16 = 16'h8000; q16 = 16'h7FFF; end
        else begin m16 = 16'($urandom); q16 = 16'($urandom); end
        @(negedge clk); #1;
        s16 = 1'b0;
        wait_idle16();
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      for (int j = 0; j < 1000; j++) begin
        @(negedge clk); #1;
        s3 = 1'b1; m3 = 3'($urandom); q3 = 3'($urandom);
        @(negedge clk); #1;
        s3 = 1'b0;
        wait_idle3();
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    join

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
